// File: rtl/obsidian_wb_arbiter.sv
// Write-back arbiter for the obsidian register file's single write port, plus
// a per-register busy scoreboard used by issue to detect pending writes.
module obsidian_wb_arbiter #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    output logic          iss_ready,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_rd,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic [AW-1:0] rm_control,
    input  logic [AW-1:0] rn_control,
    output logic          rm_busy,
    output logic          rn_busy,
    output logic [AW-1:0] rd_control,
    output logic [DW-1:0] rd_input,
    output logic [AW:0]   busy_count
);

    typedef enum logic {GNT_ALU = 1'b0, GNT_LD = 1'b1} gnt_e;

    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     busy_count_q, busy_count_d;
    logic [AW-1:0]   rd_control_q, rd_control_d;
    logic [DW-1:0]   rd_input_q, rd_input_d;
    gnt_e            last_gnt_q, last_gnt_d;

    logic            gnt_alu_s, gnt_ld_s, gnt_any_s;
    logic [AW-1:0]   wr_rd_s;
    logic [DW-1:0]   wr_data_s;
    logic            set_s, clr_s;

    // Round-robin grant: on contention the requester not granted last time wins.
    always_comb begin
        gnt_alu_s = alu_valid & (~ld_valid | (last_gnt_q == GNT_LD));
        gnt_ld_s  = ld_valid & (~alu_valid | (last_gnt_q == GNT_ALU));
        gnt_any_s = gnt_alu_s | gnt_ld_s;
        if (gnt_alu_s) begin
            wr_rd_s   = alu_rd;
            wr_data_s = alu_data;
        end else begin
            wr_rd_s   = ld_rd;
            wr_data_s = ld_data;
        end
    end

    // Scoreboard lookups; busy[0] is never set so r0 always reads as free.
    always_comb begin
        iss_ready = iss_valid & ~busy_q[iss_rd];
        rm_busy   = busy_q[rm_control];
        rn_busy   = busy_q[rn_control];
        alu_ready = gnt_alu_s;
        ld_ready  = gnt_ld_s;
    end

    // Next-state: a clear needs busy=1 and a set needs busy=0, so they never hit one register.
    always_comb begin
        set_s        = iss_ready & (iss_rd != {AW{1'b0}});
        clr_s        = gnt_any_s & (wr_rd_s != {AW{1'b0}}) & busy_q[wr_rd_s];
        busy_d       = busy_q;
        rd_control_d = rd_control_q;
        rd_input_d   = rd_input_q;
        last_gnt_d   = last_gnt_q;
        if (clr_s) begin
            busy_d[wr_rd_s] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (set_s) begin
            busy_d[iss_rd] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_count_d = busy_count_q + {{AW{1'b0}}, set_s} - {{AW{1'b0}}, clr_s};
        if (gnt_any_s) begin
            last_gnt_d = gnt_alu_s ? GNT_ALU : GNT_LD;
            if (wr_rd_s == {AW{1'b0}}) begin
                rd_control_d = {AW{1'b0}};
                rd_input_d   = {DW{1'b0}};
            end else begin
                rd_control_d = wr_rd_s;
                rd_input_d   = wr_data_s;
            end
        end else begin
            last_gnt_d = last_gnt_q;
        end
    end

    // State registers; reset leaves last_gnt at LD so the ALU wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= {NREG{1'b0}};
            busy_count_q <= {(AW+1){1'b0}};
            rd_control_q <= {AW{1'b0}};
            rd_input_q   <= {DW{1'b0}};
            last_gnt_q   <= GNT_LD;
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            rd_control_q <= rd_control_d;
            rd_input_q   <= rd_input_d;
            last_gnt_q   <= last_gnt_d;
        end
    end

    assign rd_control = rd_control_q;
    assign rd_input   = rd_input_q;
    assign busy_count = busy_count_q;

endmodule

// File: tb/tb_obsidian_wb_arbiter.sv
// Table-driven bench for obsidian_wb_arbiter with a write-port scoreboard queue
// and hand-written sequences for reset and mid-run reset.
module tb_obsidian_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          iss_valid = 1'b0;
    logic [AW-1:0] iss_rd = '0;
    logic          iss_ready;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          alu_ready;
    logic          ld_valid = 1'b0;
    logic [AW-1:0] ld_rd = '0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_ready;
    logic [AW-1:0] rm_control = '0;
    logic [AW-1:0] rn_control = '0;
    logic          rm_busy, rn_busy;
    logic [AW-1:0] rd_control;
    logic [DW-1:0] rd_input;
    logic [AW:0]   busy_count;

    obsidian_wb_arbiter #(.DW(DW), .AW(AW), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .rm_control(rm_control), .rn_control(rn_control),
        .rm_busy(rm_busy), .rn_busy(rn_busy),
        .rd_control(rd_control), .rd_input(rd_input), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [AW-1:0] ird;
        logic          av;
        logic [AW-1:0] ard;
        logic [DW-1:0] adat;
        logic          lv;
        logic [AW-1:0] lrd;
        logic [DW-1:0] ldat;
        logic [AW-1:0] rm;
        logic [AW-1:0] rn;
        logic          e_iss;
        logic          e_alu;
        logic          e_ld;
        logic          e_rmb;
        logic          e_rnb;
        logic [AW:0]   e_cnt;
    } vec_t;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    vec_t vecs[20];
    wr_t  sb_q[$];
    wr_t  exp_wr;
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic vec_t mkv(input logic iv, input int ird, input logic av, input int ard,
                                 input logic [DW-1:0] adat, input logic lv, input int lrd,
                                 input logic [DW-1:0] ldat, input int rm, input int rn,
                                 input logic e_iss, input logic e_alu, input logic e_ld,
                                 input logic e_rmb, input logic e_rnb, input int e_cnt);
        vec_t v;
        v.iv = iv;   v.ird = AW'(ird);
        v.av = av;   v.ard = AW'(ard); v.adat = adat;
        v.lv = lv;   v.lrd = AW'(lrd); v.ldat = ldat;
        v.rm = AW'(rm); v.rn = AW'(rn);
        v.e_iss = e_iss; v.e_alu = e_alu; v.e_ld = e_ld;
        v.e_rmb = e_rmb; v.e_rnb = e_rnb; v.e_cnt = (AW+1)'(e_cnt);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one vector at negedge, check combinational outputs, then the written port after posedge.
    task automatic apply(input int idx);
        vec_t v;
        wr_t  got;
        v = vecs[idx];
        @(negedge clk);
        iss_valid = v.iv; iss_rd = v.ird;
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
        ld_valid = v.lv;  ld_rd = v.lrd;  ld_data = v.ldat;
        rm_control = v.rm; rn_control = v.rn;
        #1;
        check($sformatf("v%0d iss_ready", idx), 64'(iss_ready), 64'(v.e_iss));
        check($sformatf("v%0d alu_ready", idx), 64'(alu_ready), 64'(v.e_alu));
        check($sformatf("v%0d ld_ready", idx), 64'(ld_ready), 64'(v.e_ld));
        check($sformatf("v%0d rm_busy", idx), 64'(rm_busy), 64'(v.e_rmb));
        check($sformatf("v%0d rn_busy", idx), 64'(rn_busy), 64'(v.e_rnb));
        check($sformatf("v%0d busy_count", idx), 64'(busy_count), 64'(v.e_cnt));
        if (v.e_alu) begin
            exp_wr.rd   = v.ard;
            exp_wr.data = (v.ard == '0) ? '0 : v.adat;
        end else if (v.e_ld) begin
            exp_wr.rd   = v.lrd;
            exp_wr.data = (v.lrd == '0) ? '0 : v.ldat;
        end
        sb_q.push_back(exp_wr);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check($sformatf("v%0d scoreboard empty", idx), 64'd0, 64'd1);
        end else begin
            got = sb_q.pop_front();
            check($sformatf("v%0d rd_control", idx), 64'(rd_control), 64'(got.rd));
            check($sformatf("v%0d rd_input", idx), 64'(rd_input), 64'(got.data));
        end
    endtask

    initial begin
        //              iv ird av ard adat          lv lrd ldat      rm  rn  iss alu ld rmb rnb cnt
        vecs[0]  = mkv(1, 5,  0, 0,  32'h0,        0, 0,  32'h0,    5,  0,  1,  0,  0, 0,  0,  0);
        vecs[1]  = mkv(1, 5,  0, 0,  32'h0,        0, 0,  32'h0,    5,  0,  0,  0,  0, 1,  0,  1);
        vecs[2]  = mkv(0, 0,  1, 5,  32'hDEADBEEF, 0, 0,  32'h0,    5,  0,  0,  1,  0, 1,  0,  1);
        vecs[3]  = mkv(0, 0,  0, 0,  32'h0,        0, 0,  32'h0,    5,  0,  0,  0,  0, 0,  0,  0);
        vecs[4]  = mkv(0, 0,  0, 0,  32'h0,        1, 1,  32'h11,   5,  1,  0,  0,  1, 0,  0,  0);
        vecs[5]  = mkv(0, 0,  1, 2,  32'hA0,       1, 3,  32'hB0,   2,  3,  0,  1,  0, 0,  0,  0);
        vecs[6]  = mkv(0, 0,  1, 2,  32'hA1,       1, 3,  32'hB0,   2,  3,  0,  0,  1, 0,  0,  0);
        vecs[7]  = mkv(0, 0,  1, 2,  32'hA1,       1, 3,  32'hB1,   2,  3,  0,  1,  0, 0,  0,  0);
        vecs[8]  = mkv(0, 0,  1, 2,  32'hA2,       1, 3,  32'hB1,   2,  3,  0,  0,  1, 0,  0,  0);
        vecs[9]  = mkv(1, 0,  0, 0,  32'h0,        0, 0,  32'h0,    0,  0,  1,  0,  0, 0,  0,  0);
        vecs[10] = mkv(0, 0,  0, 0,  32'h0,        1, 0,  32'h1234, 0,  0,  0,  0,  1, 0,  0,  0);
        vecs[11] = mkv(1, 7,  0, 0,  32'h0,        0, 0,  32'h0,    7,  0,  1,  0,  0, 0,  0,  0);
        vecs[12] = mkv(1, 7,  1, 7,  32'h77,       0, 0,  32'h0,    7,  0,  0,  1,  0, 1,  0,  1);
        vecs[13] = mkv(1, 7,  0, 0,  32'h0,        0, 0,  32'h0,    7,  0,  1,  0,  0, 0,  0,  0);
        vecs[14] = mkv(1, 9,  0, 0,  32'h0,        0, 0,  32'h0,    7,  9,  1,  0,  0, 1,  0,  1);
        vecs[15] = mkv(1, 3,  1, 9,  32'h99,       0, 0,  32'h0,    3,  9,  1,  1,  0, 0,  1,  2);
        vecs[16] = mkv(0, 0,  0, 0,  32'h0,        0, 0,  32'h0,    3,  9,  0,  0,  0, 1,  0,  2);
        vecs[17] = mkv(1, 12, 0, 0,  32'h0,        0, 0,  32'h0,    12, 7,  1,  0,  0, 0,  1,  2);
        vecs[18] = mkv(0, 0,  1, 7,  32'hAA,       1, 3,  32'hBB,   12, 3,  0,  1,  0, 0,  0,  0);
        vecs[19] = mkv(0, 0,  1, 7,  32'hAC,       1, 3,  32'hBB,   12, 3,  0,  0,  1, 0,  0,  0);

        exp_wr.rd = '0;
        exp_wr.data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        iss_rd = 5'd5;
        iss_valid = 1'b1;
        #1;
        check("reset rd_control", 64'(rd_control), 64'd0);
        check("reset rd_input", 64'(rd_input), 64'd0);
        check("reset busy_count", 64'(busy_count), 64'd0);
        check("reset rm_busy", 64'(rm_busy), 64'd0);
        check("reset rn_busy", 64'(rn_busy), 64'd0);
        check("reset iss_ready r5", 64'(iss_ready), 64'd1);
        iss_valid = 1'b0;

        for (int i = 0; i < 18; i++) apply(i);

        // Mid-run reset with r7, r3, r12 busy and both requesters valid.
        @(negedge clk);
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hAA;
        ld_valid = 1'b1;  ld_rd = 5'd3;  ld_data = 32'hBB;
        rm_control = 5'd12; rn_control = 5'd3;
        #1;
        check("pre-reset busy_count", 64'(busy_count), 64'd3);
        check("pre-reset ld_ready", 64'(ld_ready), 64'd1);
        check("pre-reset alu_ready", 64'(alu_ready), 64'd0);
        check("pre-reset rd_control", 64'(rd_control), 64'd9);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid-reset rd_control", 64'(rd_control), 64'd0);
        check("mid-reset rd_input", 64'(rd_input), 64'd0);
        check("mid-reset busy_count", 64'(busy_count), 64'd0);
        check("mid-reset rm_busy", 64'(rm_busy), 64'd0);
        check("mid-reset rn_busy", 64'(rn_busy), 64'd0);
        alu_valid = 1'b0;
        ld_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        exp_wr.rd = '0;
        exp_wr.data = '0;

        apply(18);
        apply(19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
